// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared types and constants for the FIFO read-side streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t       c_OCC_EMPTY = 2'd0;
  localparam logic [2:0] c_POP_LIMIT = 3'd2;
  localparam logic       c_ACCEPT    = 1'b1;

  function automatic logic handshake(input logic valid, input logic ready);
    return (valid == c_ACCEPT) && (ready == c_ACCEPT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
// ============================================================================
// Module   : fifo_rd_skid_buf
// Brief    : Two-entry register buffer with head/tail pointers and clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  count
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_head;
  logic                  r_tail;
  occ_t                  r_count;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= c_OCC_EMPTY;
    end else if (clear) begin
      // Storage is left as-is; only pointers and occupancy are discarded.
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= c_OCC_EMPTY;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= ~r_tail;
      end
      if (pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count - {1'b0, pop} + {1'b0, push};
    end
  end

  assign head_data = r_mem[r_head];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
// ============================================================================
// Module   : fifo_rd_streamer
// Brief    : Drains an async FIFO read port into a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  drain_cnt,
  output logic                  busy
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_drain_cnt;
  occ_t                 w_count;
  logic                 w_deq;
  logic                 w_push;
  logic [2:0]           w_need;

  assign m_valid = (w_count != c_OCC_EMPTY);
  assign w_deq   = handshake(m_valid, m_ready);
  assign w_push  = r_inflight & ~flush;

  // Slots needed after this cycle if one more pop is issued; deq implies count >= 1.
  assign w_need    = {1'b0, w_count} - {2'b00, w_deq} + {2'b00, r_inflight} + 3'd1;
  assign fifo_r_en = rrst_n & ~flush & ~fifo_empty & (w_need <= c_POP_LIMIT);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_inflight  <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_inflight <= fifo_r_en;
      if (w_deq) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .push      (w_push),
    .push_data (fifo_rdata),
    .pop       (w_deq),
    .clear     (flush),
    .head_data (m_data),
    .count     (w_count)
  );

  assign drain_cnt = r_drain_cnt;
  assign busy      = m_valid | r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
// ============================================================================
// Module   : tb_fifo_rd_streamer
// Brief    : Self-checking bench with a behavioural FIFO and data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_streamer;

  logic        rclk;
  logic        rrst_n;
  wire         fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        flush;
  logic [15:0] drain_cnt;
  logic        busy;

  fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .drain_cnt  (drain_cnt),
    .busy       (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, reset on the same rrst_n.
  logic [7:0]  fmem [0:255];
  int unsigned wr_count = 0;
  int unsigned rd_count = 0;
  logic [7:0]  exp_q [$];

  assign fifo_empty = (wr_count == rd_count);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count   <= wr_count;
      fifo_rdata <= 8'h00;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_rdata <= fmem[rd_count[7:0]];
      rd_count   <= rd_count + 1;
    end
  end

  task automatic push_word(input logic [7:0] v);
    fmem[wr_count[7:0]] = v;
    wr_count = wr_count + 1;
    exp_q.push_back(v);
  endtask

  // Monitor: scoreboard on handshakes, hold stability, underflow protection.
  int         hs_count = 0;
  logic       hold_pending = 1'b0;
  logic       flush_d = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge rclk) begin
    if (rrst_n) begin
      if (fifo_empty) check("no_pop_when_empty", {31'd0, fifo_r_en}, 32'd0);
      if (hold_pending && !flush_d) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {24'd0, m_data}, {24'd0, hold_data});
      end
      if (m_valid && m_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
      hold_pending = m_valid & ~m_ready;
      hold_data    = m_data;
      flush_d      = flush;
    end else begin
      hold_pending = 1'b0;
    end
  end

  typedef struct {
    logic       push;
    int         n_push;
    logic [7:0] base;
    logic       ready;
    logic       flush;
    int         drop;
    logic       exp_r_en;
    logic       exp_valid;
    logic       exp_busy;
    int         exp_drain;
  } vec_t;

  vec_t t_single [5];
  vec_t t_flush  [11];
  int   pend_drop = 0;

  task automatic apply_row(input vec_t v, input string tag);
    @(posedge rclk); #1;
    repeat (pend_drop) void'(exp_q.pop_front());
    pend_drop = v.drop;
    m_ready   = v.ready;
    flush     = v.flush;
    if (v.push) for (int k = 0; k < v.n_push; k++) push_word(v.base + 8'(k));
    @(negedge rclk);
    check({tag, "_r_en"},  {31'd0, fifo_r_en}, {31'd0, v.exp_r_en});
    check({tag, "_valid"}, {31'd0, m_valid},   {31'd0, v.exp_valid});
    check({tag, "_busy"},  {31'd0, busy},      {31'd0, v.exp_busy});
    check({tag, "_drain"}, {16'd0, drain_cnt}, v.exp_drain);
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n = 0;
    @(negedge rclk);
    while (!m_valid && n < limit) begin
      @(negedge rclk);
      n++;
    end
    if (!m_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drained(input int limit, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy || !fifo_empty) && n < limit) begin
      @(negedge rclk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    //                 push n  base   rdy flsh drop r_en val busy drain
    t_single[0] = '{1'b1, 1, 8'hA1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0};
    t_single[1] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0};
    t_single[2] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0};
    t_single[3] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
    t_single[4] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};

    // Flush with one buffered + one in flight, then with two buffered and a handshake.
    t_flush[0]  = '{1'b1, 5, 8'h50, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 25};
    t_flush[1]  = '{1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 25};
    t_flush[2]  = '{1'b0, 0, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 25};
    t_flush[3]  = '{1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 25};
    t_flush[4]  = '{1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 25};
    t_flush[5]  = '{1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 25};
    t_flush[6]  = '{1'b0, 0, 8'h00, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 25};
    t_flush[7]  = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 26};
    t_flush[8]  = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 26};
    t_flush[9]  = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 26};
    t_flush[10] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 27};

    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    repeat (3) @(posedge rclk);
    check("rst_valid", {31'd0, m_valid},   32'd0);
    check("rst_data",  {24'd0, m_data},    32'd0);
    check("rst_drain", {16'd0, drain_cnt}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_r_en",  {31'd0, fifo_r_en}, 32'd0);
    #1 rrst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply_row(t_single[i], "single");

    // Full-throughput burst of 16 words.
    @(posedge rclk); #1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    wait_valid(10, "burst");
    for (int i = 1; i < 16; i++) begin
      @(negedge rclk);
      check("burst_no_gap", {31'd0, m_valid}, 32'd1);
    end
    @(negedge rclk);
    check("burst_end_valid", {31'd0, m_valid}, 32'd0);
    check("burst_drain", {16'd0, drain_cnt}, 32'd17);

    // Backpressure: only two pops may be issued.
    begin
      int pops = 0;
      @(posedge rclk); #1;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'(i));
      for (int i = 0; i < 8; i++) begin
        @(negedge rclk);
        if (fifo_r_en) pops++;
      end
      check("bp_pops", pops, 32'd2);
      check("bp_valid", {31'd0, m_valid}, 32'd1);
      check("bp_head", {24'd0, m_data}, 32'h00);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge rclk); #1;
      m_ready = 1'b1;
      wait_drained(50, "bp");
      check("bp_drain", {16'd0, drain_cnt}, 32'd25);
    end

    for (int i = 0; i < 11; i++) apply_row(t_flush[i], "flush");
    @(posedge rclk); #1;
    repeat (pend_drop) void'(exp_q.pop_front());
    pend_drop = 0;
    check("flush_sb_empty", exp_q.size(), 32'd0);

    // Asynchronous reset while a word is presented.
    m_ready = 1'b0;
    push_word(8'hC0);
    push_word(8'hC1);
    wait_valid(10, "arst");
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", {31'd0, m_valid},   32'd0);
    check("arst_data",  {24'd0, m_data},    32'd0);
    check("arst_drain", {16'd0, drain_cnt}, 32'd0);
    check("arst_busy",  {31'd0, busy},      32'd0);
    check("arst_r_en",  {31'd0, fifo_r_en}, 32'd0);
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("post_rst_valid", {31'd0, m_valid}, 32'd0);
    end

    // Counter wrap: 65535 words to reach all-ones, then 2 more.
    begin
      int pushed = 0;
      int cyc = 0;
      m_ready = 1'b1;
      while (pushed < 65535 && cyc < 80000) begin
        @(posedge rclk); #1;
        if ((wr_count - rd_count) < 4) begin
          push_word(8'(pushed));
          pushed++;
        end
        cyc++;
      end
      check("wrap_feed_done", pushed, 32'd65535);
      wait_drained(20, "wrap_a");
      check("wrap_all_ones", {16'd0, drain_cnt}, 32'h0000_FFFF);
      @(posedge rclk); #1;
      push_word(8'h5A);
      push_word(8'hA5);
      wait_valid(10, "wrap_b");
      wait_drained(20, "wrap_b");
      check("wrap_to_one", {16'd0, drain_cnt}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
